fp16_sub_pipe: RTL and testbench

- Pipelined IEEE-754 binary16 subtractor computing result = a − b, for the TensorCore datapath.
- Complements the combinational fp16 adder: it covers the opposite-sign/difference direction with full leading-zero normalization, subnormal support and round-to-nearest-even.
- Three-stage pipeline with valid/ready handshakes on both ends. Sustains one operation per cycle when not back-pressured.

---
 rtl/fp16_pkg.sv | 58 +++++
 rtl/fp16_lzc.sv | 14 +
 rtl/fp16_sub_pipe.sv | 152 +++++++++++++++
 tb/tb_fp16_sub_pipe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - binary16 format constants, operand and pipeline-stage types
package fp16_pkg;
    localparam int DWIDTH = 16;
    localparam int EWIDTH = 5;
    localparam int MWIDTH = 10;
    localparam int RWIDTH = 3;
    localparam int BIAS   = (1 << (EWIDTH - 1)) - 1;
    localparam int EMAX   = 2 * BIAS + 1;
    localparam int XWIDTH = MWIDTH + 1 + RWIDTH;

    localparam logic [DWIDTH-1:0] QNAN    = 16'h7FFF;
    localparam logic [DWIDTH-1:0] POS_INF = 16'h7C00;

    typedef struct packed {
        logic              sign;
        logic [EWIDTH-1:0] exp;
        logic [MWIDTH:0]   mant;
        logic              isZero;
        logic              isInf;
        logic              isNaN;
    } unpacked_t;

    typedef struct packed {
        logic              special;
        logic [DWIDTH-1:0] spec_res;
        logic              spec_exc;
        logic              sign;
        logic              sub;
        logic [EWIDTH-1:0] exp;
        logic [XWIDTH-1:0] mant_l;
        logic [XWIDTH-1:0] mant_s;
    } s1_t;

    typedef struct packed {
        logic              special;
        logic [DWIDTH-1:0] spec_res;
        logic              spec_exc;
        logic              sign;
        logic [EWIDTH:0]   exp;
        logic [XWIDTH:0]   mant;
    } s2_t;

    // Subnormals take exponent 1 with a zero hidden bit so alignment needs no special case.
    function automatic unpacked_t unpack_op(input logic [DWIDTH-1:0] x, input logic flip);
        unpacked_t u;
        logic [EWIDTH-1:0] e;
        logic [MWIDTH-1:0] f;
        e = x[DWIDTH-2:MWIDTH];
        f = x[MWIDTH-1:0];
        u.sign   = x[DWIDTH-1] ^ flip;
        u.exp    = (e == '0) ? EWIDTH'(1) : e;
        u.mant   = {(e != '0), f};
        u.isZero = (e == '0) && (f == '0);
        u.isInf  = (e == EWIDTH'(EMAX)) && (f == '0);
        u.isNaN  = (e == EWIDTH'(EMAX)) && (f != '0);
        return u;
    endfunction
endpackage

// File: rtl/fp16_lzc.sv
// rtl/fp16_lzc.sv - combinational leading-zero counter over the extended mantissa
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [XWIDTH-1:0] value,
    output logic [3:0]        count
);
    always_comb begin
        count = 4'(XWIDTH);
        for (int i = 0; i < XWIDTH; i++) begin
            if (value[i]) count = 4'(XWIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/fp16_sub_pipe.sv
// rtl/fp16_sub_pipe.sv - three-stage binary16 subtractor with valid/ready handshakes
module fp16_sub_pipe
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] a_operand,
    input  logic [DWIDTH-1:0] b_operand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              Exception
);
    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    unpacked_t         ua, ub;
    logic              a_big, l_sign, s_sign;
    logic [EWIDTH-1:0] l_exp, s_exp, exp_diff;
    logic [MWIDTH:0]   l_mant, s_mant;
    logic [2*XWIDTH-1:0] wide;
    logic [XWIDTH-1:0] aligned;

    always_comb begin
        s1_d     = '0;
        ua       = unpack_op(a_operand, 1'b0);
        ub       = unpack_op(b_operand, 1'b1);
        a_big    = a_operand[DWIDTH-2:0] >= b_operand[DWIDTH-2:0];
        l_sign   = a_big ? ua.sign : ub.sign;
        s_sign   = a_big ? ub.sign : ua.sign;
        l_exp    = a_big ? ua.exp  : ub.exp;
        s_exp    = a_big ? ub.exp  : ua.exp;
        l_mant   = a_big ? ua.mant : ub.mant;
        s_mant   = a_big ? ub.mant : ua.mant;
        exp_diff = l_exp - s_exp;
        wide     = {s_mant, {RWIDTH{1'b0}}, {XWIDTH{1'b0}}} >> exp_diff;
        if (exp_diff >= EWIDTH'(XWIDTH)) aligned = {{(XWIDTH-1){1'b0}}, |s_mant};
        else aligned = {wide[2*XWIDTH-1:XWIDTH+1], wide[XWIDTH] | (|wide[XWIDTH-1:0])};

        s1_d.sign   = l_sign;
        s1_d.sub    = l_sign ^ s_sign;
        s1_d.exp    = l_exp;
        s1_d.mant_l = {l_mant, {RWIDTH{1'b0}}};
        s1_d.mant_s = aligned;

        if (ua.isNaN || ub.isNaN) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = QNAN;
            s1_d.spec_exc = 1'b1;
        end else if (ua.isInf && ub.isInf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = (ua.sign != ub.sign) ? QNAN : {ua.sign, POS_INF[DWIDTH-2:0]};
            s1_d.spec_exc = (ua.sign != ub.sign);
        end else if (ua.isInf || ub.isInf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {ua.isInf ? ua.sign : ub.sign, POS_INF[DWIDTH-2:0]};
        end else if (ua.isZero && ub.isZero) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {ua.sign & ub.sign, {(DWIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        s2_d          = '0;
        s2_d.special  = s1_q.special;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.spec_exc = s1_q.spec_exc;
        s2_d.sign     = s1_q.sign;
        s2_d.exp      = {1'b0, s1_q.exp};
        s2_d.mant     = s1_q.sub ? ({1'b0, s1_q.mant_l} - {1'b0, s1_q.mant_s})
                                 : ({1'b0, s1_q.mant_l} + {1'b0, s1_q.mant_s});
    end

    logic [3:0]        lz, sh;
    logic [EWIDTH:0]   e_lim, e_norm, e_field;
    logic [XWIDTH-1:0] m_norm;
    logic              rnd_up, ovf;
    logic [DWIDTH-1:0] packed_v, res_d;
    logic              exc_d;

    fp16_lzc u_lzc (
        .value (s2_q.mant[XWIDTH-1:0]),
        .count (lz)
    );

    always_comb begin
        sh    = '0;
        e_lim = s2_q.exp - 1'b1;
        if (s2_q.mant[XWIDTH]) begin
            m_norm = {s2_q.mant[XWIDTH:2], s2_q.mant[1] | s2_q.mant[0]};
            e_norm = s2_q.exp + 1'b1;
        end else begin
            // Left shift stops at exponent 1; anything still unnormalized is subnormal.
            sh     = ({2'b0, lz} < e_lim) ? lz : e_lim[3:0];
            m_norm = s2_q.mant[XWIDTH-1:0] << sh;
            e_norm = s2_q.exp - {2'b0, sh};
        end
        e_field  = m_norm[XWIDTH-1] ? e_norm : '0;
        rnd_up   = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        // Rounding carry ripples straight from the fraction into the exponent field.
        packed_v = {e_field, m_norm[XWIDTH-2:RWIDTH]} + DWIDTH'(rnd_up);
        ovf      = packed_v[DWIDTH-1:MWIDTH] >= (EWIDTH+1)'(EMAX);
        if (s2_q.special) begin
            res_d = s2_q.spec_res;
            exc_d = s2_q.spec_exc;
        end else if (ovf) begin
            res_d = {s2_q.sign, POS_INF[DWIDTH-2:0]};
            exc_d = 1'b1;
        end else begin
            res_d = {s2_q.sign & (packed_v != '0), packed_v[DWIDTH-2:0]};
            exc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            result    <= '0;
            Exception <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) s2_q <= s2_d;
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    result    <= res_d;
                    Exception <= exc_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp16_sub_pipe.sv
// tb/tb_fp16_sub_pipe.sv - scoreboard bench for the pipelined binary16 subtractor
module tb_fp16_sub_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, Exception;
    logic [15:0] a_operand, b_operand, result;

    always #5 clk = ~clk;

    fp16_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Exception (Exception)
    );

    typedef struct {
        logic [15:0] res;
        logic        exc;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input logic e, input bit track, input bit lat);
        @(negedge clk);
        in_valid  = 1'b1;
        a_operand = a;
        b_operand = b;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            if (in_ready) begin
                if (track) sb.push_back('{r, e, cyc, lat});
                return;
            end
        end
        timeout("accept");
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        timeout("drain");
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                timeout("unexpected_output");
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("exception", 32'(Exception), 32'(mon_e.exc));
                if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.acc), 32'd3);
                n_out++;
            end
        end
    end

    logic [15:0] tv_a [11] = '{16'h4200, 16'h3C00, 16'h3C00, 16'h8000, 16'h0000, 16'h7C00,
                               16'h7E00, 16'h7C00, 16'h7BFF, 16'h0400, 16'h3C00};
    logic [15:0] tv_b [11] = '{16'h3C00, 16'h9000, 16'h3C00, 16'h0000, 16'h3C00, 16'h7C00,
                               16'h3C00, 16'hFC00, 16'hFBFF, 16'h0001, 16'h3C01};
    logic [15:0] tv_r [11] = '{16'h4000, 16'h3C00, 16'h0000, 16'h8000, 16'hBC00, 16'h7FFF,
                               16'h7FFF, 16'h7C00, 16'h7C00, 16'h03FF, 16'h9400};
    logic        tv_e [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic [15:0] st_a [6] = '{16'h3C00, 16'h4000, 16'h4400, 16'h3C00, 16'h4500, 16'h3800};
    logic [15:0] st_b [6] = '{16'h3800, 16'h3C00, 16'h4000, 16'hBC00, 16'h3C00, 16'h3C00};
    logic [15:0] st_r [6] = '{16'h3800, 16'h3C00, 16'h4000, 16'h4000, 16'h4400, 16'hB800};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_operand = '0;
        b_operand = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_exception", 32'(Exception), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) send(tv_a[i], tv_b[i], tv_r[i], tv_e[i], 1'b1, 1'b1);
        idle();
        drain();

        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(st_a[i], st_b[i], st_r[i], 1'b0, 1'b1, 1'b0);
                idle();
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    if (k > 0) check("stall_hold", 32'(result), 32'h3800);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'h7E00, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        send(16'h4200, 16'h3C00, 16'h0, 1'b0, 1'b0, 1'b0);
        idle();
        for (int n = 0; n < 20; n++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_result", 32'(result), 32'd0);
        check("async_exception", 32'(Exception), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        send(16'h4200, 16'h3C00, 16'h4000, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        repeat (6) @(negedge clk);
        check("output_count", 32'(n_out), 32'd18);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
